// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants for the fetch stage and the
// downstream stage registers.
package pipe_pkg;

  typedef logic [15:0] word_t;

  localparam logic [3:0] HLT_OP  = 4'hF;
  localparam word_t      NOP_WORD = 16'h0000;

  typedef enum logic {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/dff.sv
// Generic enabled flop with synchronous active-high reset.
module dff #(
  parameter int          W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Reset wins; otherwise load when enabled.
  always_ff @(posedge clk) begin
    if (rst)     q <= RST_VAL;
    else if (en) q <= d;
  end

endmodule

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: instruction, PC+2 and valid bit.
// flush loads a bubble and overrides wen.
module if_id_reg
  import pipe_pkg::*;
#(
  parameter word_t NOP_INSTR = NOP_WORD
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  wen,
  input  logic  flush,
  input  word_t instr_in,
  input  word_t pc_in,
  output word_t instr,
  output word_t pc,
  output logic  valid
);

  logic  en;
  word_t instr_d, pc_d;
  logic  valid_d;

  // Select the bubble on flush, the fetched word otherwise.
  always_comb begin
    en      = wen | flush;
    instr_d = flush ? NOP_INSTR : instr_in;
    pc_d    = flush ? 16'h0000  : pc_in;
    valid_d = ~flush;
  end

  dff #(.W(16), .RST_VAL(NOP_INSTR)) u_instr (
    .clk(clk), .rst(rst), .en(en), .d(instr_d), .q(instr));
  dff #(.W(16), .RST_VAL(16'h0000)) u_pc (
    .clk(clk), .rst(rst), .en(en), .d(pc_d), .q(pc));
  dff #(.W(1), .RST_VAL(1'b0)) u_valid (
    .clk(clk), .rst(rst), .en(en), .d(valid_d), .q(valid));

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, halt FSM, fetched-instruction counter,
// and the IF/ID register. Priority per edge: rst > stall > redirect > normal.
module fetch_stage
  import pipe_pkg::*;
#(
  parameter word_t      RESET_PC   = 16'h0000,
  parameter logic [3:0] HLT_OPCODE = HLT_OP,
  parameter word_t      NOP_INSTR  = NOP_WORD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  input  logic [15:0] imem_data,
  output logic [15:0] imem_addr,
  output logic [15:0] IFIDinstr,
  output logic [15:0] IFIDpc,
  output logic        IFIDvalid,
  output logic        fetch_halted,
  output logic [15:0] fetch_count
);

  word_t        pc_q, pc_d;
  word_t        cnt_q, cnt_d;
  fetch_state_e state_q, state_d;
  logic         ifid_wen, ifid_flush;
  logic         redir;
  word_t        pc_plus2;

  // A stalled ID stage re-resolves its branch next cycle, so ignore it now.
  assign redir    = branch_taken & ~stall;
  assign pc_plus2 = pc_q + 16'd2;

  // Next PC, state, counter and IF/ID control.
  always_comb begin
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    state_d    = state_q;
    ifid_wen   = 1'b0;
    ifid_flush = 1'b0;
    unique case (state_q)
      FETCH: begin
        if (stall) begin
          // hold everything
        end else if (redir) begin
          pc_d       = branch_target;
          ifid_flush = 1'b1;
        end else begin
          ifid_wen = 1'b1;
          cnt_d    = cnt_q + 16'd1;
          if (imem_data[15:12] == HLT_OPCODE) state_d = HALTED;
          else                                pc_d    = pc_plus2;
        end
      end
      HALTED: begin
        if (stall) begin
          // HLT stays in IF/ID
        end else if (redir) begin
          // an older branch squashes the speculative HLT
          pc_d       = branch_target;
          ifid_flush = 1'b1;
          state_d    = FETCH;
        end else begin
          ifid_flush = 1'b1;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // PC, counter and state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      cnt_q   <= 16'h0000;
      state_q <= FETCH;
    end else begin
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
    .clk     (clk),
    .rst     (rst),
    .wen     (ifid_wen),
    .flush   (ifid_flush),
    .instr_in(imem_data),
    .pc_in   (pc_plus2),
    .instr   (IFIDinstr),
    .pc      (IFIDpc),
    .valid   (IFIDvalid)
  );

  assign imem_addr    = pc_q;
  assign fetch_halted = (state_q == HALTED);
  assign fetch_count  = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, sequential fetch, stall,
// redirect, HLT freeze/squash, PC and counter wrap, reset mid-halt.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, stall, branch_taken;
  logic [15:0] branch_target, imem_data, imem_addr;
  logic [15:0] IFIDinstr, IFIDpc, fetch_count;
  logic        IFIDvalid, fetch_halted;
  logic        hlt_en;
  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_cnt;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_data(imem_data),
    .imem_addr(imem_addr), .IFIDinstr(IFIDinstr), .IFIDpc(IFIDpc),
    .IFIDvalid(IFIDvalid), .fetch_halted(fetch_halted),
    .fetch_count(fetch_count)
  );

  // Instruction memory model; the HLT at 8 is only present when hlt_en=1.
  always_comb begin
    case (imem_addr)
      16'h0000: imem_data = 16'h1123;
      16'h0002: imem_data = 16'h2456;
      16'h0004: imem_data = 16'h3789;
      16'h0008: imem_data = hlt_en ? 16'hF000 : 16'h1008;
      16'hFFFE: imem_data = 16'h1000;
      default:  imem_data = {4'h1, imem_addr[11:0]};
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_if(input string tag, input logic [15:0] addr, input logic [15:0] instr,
                        input logic [15:0] pc, input logic vld, input logic hlt,
                        input logic [15:0] cnt);
    chk({tag, ".addr"},  imem_addr, addr);
    chk({tag, ".instr"}, IFIDinstr, instr);
    chk({tag, ".pc"},    IFIDpc, pc);
    chk({tag, ".valid"}, {15'd0, IFIDvalid}, {15'd0, vld});
    chk({tag, ".halt"},  {15'd0, fetch_halted}, {15'd0, hlt});
    chk({tag, ".cnt"},   fetch_count, cnt);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 16'h0000; hlt_en = 1'b1;
    tick(); tick();
    chk_if("reset", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'd0);
    rst = 1'b0;

    // sequential fetch
    tick(); chk_if("seq0", 16'h0002, 16'h1123, 16'h0002, 1'b1, 1'b0, 16'd1);
    tick(); chk_if("seq1", 16'h0004, 16'h2456, 16'h0004, 1'b1, 1'b0, 16'd2);

    // stall at PC=4 with a taken branch that must be ignored
    stall = 1'b1; branch_taken = 1'b1; branch_target = 16'h0080;
    tick(); chk_if("stall0", 16'h0004, 16'h2456, 16'h0004, 1'b1, 1'b0, 16'd2);
    tick(); chk_if("stall1", 16'h0004, 16'h2456, 16'h0004, 1'b1, 1'b0, 16'd2);
    stall = 1'b0; branch_taken = 1'b0;
    tick(); chk_if("seq2", 16'h0006, 16'h3789, 16'h0006, 1'b1, 1'b0, 16'd3);

    // redirect from PC=6 to 0x40
    branch_taken = 1'b1; branch_target = 16'h0040;
    tick(); chk_if("redir", 16'h0040, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'd3);
    branch_taken = 1'b0;
    tick(); chk_if("redir1", 16'h0042, 16'h1040, 16'h0042, 1'b1, 1'b0, 16'd4);

    // HLT at address 8
    branch_taken = 1'b1; branch_target = 16'h0008;
    tick(); branch_taken = 1'b0;
    tick(); chk_if("hlt", 16'h0008, 16'hF000, 16'h000A, 1'b1, 1'b1, 16'd5);
    stall = 1'b1;
    tick(); chk_if("hltstall", 16'h0008, 16'hF000, 16'h000A, 1'b1, 1'b1, 16'd5);
    stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); chk_if("hltbub", 16'h0008, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'd5);
    end

    // squash the speculative HLT
    branch_taken = 1'b1; branch_target = 16'h0010;
    tick(); chk_if("squash", 16'h0010, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'd5);
    branch_taken = 1'b0;
    tick(); chk_if("resume", 16'h0012, 16'h1010, 16'h0012, 1'b1, 1'b0, 16'd6);

    // PC wrap at 0xFFFE
    branch_taken = 1'b1; branch_target = 16'hFFFE;
    tick(); branch_taken = 1'b0;
    tick(); chk_if("pcwrap", 16'h0000, 16'h1000, 16'h0000, 1'b1, 1'b0, 16'd7);

    // run the counter up to 0xFFFF with no HLT in memory, then wrap it
    hlt_en = 1'b0;
    exp_cnt = 16'd7;
    while (exp_cnt != 16'hFFFF) begin
      tick();
      exp_cnt = exp_cnt + 16'd1;
    end
    chk("cnt_ffff", fetch_count, 16'hFFFF);
    chk("cnt_vld", {15'd0, IFIDvalid}, 16'd1);
    tick();
    chk("cnt_wrap", fetch_count, 16'h0000);

    // reset while halted
    hlt_en = 1'b1;
    branch_taken = 1'b1; branch_target = 16'h0008;
    tick(); branch_taken = 1'b0;
    tick(); chk("pre_rst_halt", {15'd0, fetch_halted}, 16'd1);
    rst = 1'b1; stall = 1'b1;
    tick(); chk_if("rst_halt", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'd0);
    rst = 1'b0; stall = 1'b0;
    tick(); chk_if("post_rst", 16'h0002, 16'h1123, 16'h0002, 1'b1, 1'b0, 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus the IF/ID pipeline register. It feeds the decode stage, which in turn drives the ID/EX register.
- Owns the PC and drives the instruction-memory address. It latches each fetched instruction with PC+2, applies stall and branch-redirect/flush from the hazard and branch logic, and freezes fetch when a HLT is fetched.
- Also keeps a fetched-instruction counter for debug and CPI measurement.

Parameters:
- RESET_PC, 16'h0000, PC value after reset.
- HLT_OPCODE, 4'hF, opcode (instr[15:12]) that halts fetch.
- NOP_INSTR, 16'h0000, encoding inserted as a bubble; it writes only r0, so it has no architectural effect.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- stall  in  1  load-use stall from the hazard unit; holds the PC and IF/ID.
- branch_taken  in  1  branch/BR resolved taken in ID this cycle.
- branch_target  in  16  redirect PC, valid when branch_taken=1.
- imem_data  in  16  instruction word; combinational read of imem_addr.
- imem_addr  out  16  current PC, driven combinationally from the PC register.
- IFIDinstr  out  16  registered instruction to decode.
- IFIDpc  out  16  registered PC+2 of that instruction (used by PCS and branch offset).
- IFIDvalid  out  1  1 = real instruction, 0 = bubble.
- fetch_halted  out  1  1 while fetch is frozen after a HLT.
- fetch_count  out  16  number of valid instructions latched into IF/ID; wraps.

Behaviour:
- Interface fixed: one clock clk; rst is synchronous and active-high. Its effect is visible on the first edge with rst=1, and it has priority over all other inputs.
- Reset values: PC=RESET_PC, IFIDinstr=NOP_INSTR, IFIDpc=0, IFIDvalid=0, fetch_halted=0, fetch_count=0, state=FETCH.
- Effective redirect: redir = branch_taken & ~stall. While stall=1, branch_taken is ignored, because the ID instruction is being held and will re-resolve next cycle.
- Priority each edge: rst > stall > redir > normal.
- Latency: imem_data for PC p appears on IFIDinstr one edge later.
- States: FETCH and HALTED. fetch_halted=1 exactly when the state is HALTED.
- FETCH, stall=1:
  - PC, IF/ID and fetch_count hold; state holds.
- FETCH, redir=1:
  - PC<=branch_target.
  - IF/ID flushed: instr=NOP_INSTR, valid=0, IFIDpc=0.
  - fetch_count holds; stay in FETCH.
  - The HLT-detect check is not applied to the squashed word.
- FETCH, normal:
  - IFIDinstr<=imem_data, IFIDpc<=PC+2, valid<=1, fetch_count<=fetch_count+1.
  - If imem_data[15:12]==HLT_OPCODE: PC holds and next state is HALTED.
  - Otherwise PC<=PC+2.
- HALTED, stall=1:
  - Everything holds; the HLT stays in IF/ID.
- HALTED, redir=1:
  - An older branch squashes the speculative HLT.
  - PC<=branch_target, flush IF/ID, next state FETCH.
- HALTED, otherwise:
  - PC holds; IF/ID loads a bubble (NOP_INSTR, valid=0, IFIDpc=0); fetch_count holds.
  - The HLT in the downstream stages drains normally.
- Arithmetic:
  - PC+2 is 16-bit modulo: PC=16'hFFFE wraps to 16'h0000.
  - fetch_count wraps 16'hFFFF to 16'h0000.
  - branch_target is used as given; no alignment check.
- rst asserted mid-halt or mid-stall returns the block to the reset values on that edge.

Decomposition:
- Shared package pipe_pkg:
  - HLT and NOP constants.
  - fetch state enum (FETCH, HALTED).
  - 16-bit word typedef, also reused by the downstream stage registers.
- One sub-module, if_id_reg:
  - Holds the instr/pc/valid flops, built from the team dff cell.
  - Inputs wen and flush; flush loads the bubble values.
  - The PC register, state machine and counter live in fetch_stage.

Test Plan:
- Reset, then sequential fetch: rst=1 for 2 cycles, then memory holds 16'h1123, 16'h2456, 16'h3789 at addresses 0, 2, 4. Expect IFIDinstr to follow one edge later with IFIDpc=2, 4, 6, valid=1, and fetch_count=3 after 3 edges.
- Stall: stall=1 for 2 cycles while PC=4. Expect PC, IFIDinstr and fetch_count to be unchanged for both cycles. Also assert branch_taken=1 during the stall: it is ignored and PC stays 4.
- Redirect: branch_taken=1 with branch_target=16'h0040 while PC=6. Next edge: PC=16'h0040, IFIDinstr=16'h0000, valid=0, fetch_count unchanged. Following edge: the word at 16'h0040 is latched with IFIDpc=16'h0042.
- HLT: 16'hF000 at address 8. Expect the HLT latched with valid=1, fetch_halted=1, and imem_addr stuck at 8. The next 3 edges give bubbles (valid=0) and fetch_count is frozen.
- Squashed HLT: while HALTED, pulse branch_taken=1 with target 16'h0010. Expect fetch_halted=0, PC=16'h0010, a flushed IF/ID, and normal fetch resuming.
- Wrap: force PC=16'hFFFE with 16'h1000 fetched. Expect IFIDpc=16'h0000 and next imem_addr=16'h0000. Also drive fetch_count from 16'hFFFF through one valid fetch and expect 16'h0000.
